byte_cmd_encoder: RTL and testbench
===================================

Name: byte_cmd_encoder

Overview:
- Host-side transmitter for the stc0 byte command link.
- Accepts 24-bit address / 32-bit data write commands, buffers them in a small FIFO, and serializes each into an 8-byte frame.
- The frame is driven onto the byte ingress bus (ID/IValid) of stc0_core, and the encoder honours the receiver's Rdyn back-pressure.
- Used in the loopback/self-test wrapper and as the bench driver model for the core.

Parameters:
FIFO_DEPTH, 4, number of buffered commands (power of 2, >=2)
FIFO_DEPTH_LOG2, 2, log2(FIFO_DEPTH)
GAP_CYCLES, 0, extra idle cycles forced between frames (0..15)
CMD_WRITE, 8'h01, header byte value sent first in every frame

Ports:
Clk  in  1  single clock for all logic
ARst  in  1  reset, synchronous, active-high
WriteAddr  in  24  command byte address
WriteData  in  32  command write data
WriteDataValid  in  1  push command; accepted only when Ready=1
Ready  out  1  FIFO not full, combinational from occupancy
Rdyn  in  1  receiver not ready; high stalls the byte stream
Data  out  8  serialized byte, registered
DataValid  out  1  Data qualifier, registered
Busy  out  1  FIFO non-empty or frame in progress
Overflow  out  1  sticky: push attempted while Ready=0

Behaviour:
- Reset (ARst=1 at a Clk edge):
  - Clears FIFO pointers and occupancy, and puts the FSM in IDLE.
  - Data=8'h00, DataValid=0, Busy=0, Overflow=0, Ready=1.
  - Reset mid-frame aborts the frame immediately: no further bytes are sent and the remaining FIFO entries are discarded.
- FIFO:
  - Holds 56-bit entries {WriteAddr, WriteData}, with occupancy counter 0..FIFO_DEPTH.
  - Push when WriteDataValid & Ready. Pop only in IDLE when occupancy > 0.
  - A simultaneous push and pop updates occupancy by net 0.
  - A push while full is dropped and sets Overflow. Overflow clears only on reset.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Frame format, 8 bytes, MSB first:
  - Byte 0: CMD_WRITE
  - Bytes 1-3: WriteAddr[23:16], [15:8], [7:0]
  - Bytes 4-7: WriteData[31:24], [23:16], [15:8], [7:0]
- FSM states:
  - IDLE: if occupancy > 0, pop the entry into a 64-bit shift register {CMD_WRITE, addr, data}, clear byte counter, go to SEND. Otherwise stay in IDLE.
  - SEND, each cycle with Rdyn=0: on the next edge register Data = shreg[63:56] and DataValid=1, shift left 8, increment byte counter. After byte 7 is issued, go to GAP if GAP_CYCLES>0, else IDLE.
  - SEND with Rdyn=1: on the next edge DataValid=0, Data holds its value, and shreg/counter hold. No byte is lost or repeated.
  - GAP: DataValid=0 for exactly GAP_CYCLES cycles (down-counter), then IDLE.
  - DataValid is 0 in every cycle not issuing a byte.
- Latency:
  - Command pushed in cycle t into an empty FIFO with FSM in IDLE: pop in t+1, header byte valid in t+2.
  - With no stalls, bytes are valid in t+2..t+9.
  - Back-to-back frames with GAP_CYCLES=0 have exactly one DataValid=0 cycle between them (IDLE pop cycle).
- Rdyn is sampled in SEND only; it has no effect in IDLE or GAP.
- Busy = (occupancy != 0) | (state != IDLE).

Test Plan:
- Single push WriteAddr=24'h000104, WriteData=32'hDEADBEEF, Rdyn=0 -> DataValid high cycles t+2..t+9 with bytes 01,00,01,04,DE,AD,BE,EF; Busy falls after last byte.
- Three consecutive pushes (A=1,2,3; D=32'h11111111, 32'h22222222, 32'h33333333) -> three 8-byte frames each separated by exactly one invalid cycle, in push order; Ready stays 1.
- Rdyn=1 for 3 cycles starting after byte 2 of a frame -> exactly 3 extra DataValid=0 cycles, then byte 3 resumes; the 8 bytes match the no-stall frame.
- FIFO_DEPTH=4, Rdyn held 1, push 6 commands -> Ready drops after 5th accepted (1 in shreg + 4 FIFO), 6th dropped, Overflow=1; releasing Rdyn emits 5 correct frames.
- ARst asserted after byte 4 of a frame with 2 queued commands -> next cycle DataValid=0, Busy=0, Ready=1, no further bytes until a new push.
- GAP_CYCLES=3, two queued commands -> 4 invalid cycles (3 gap + 1 pop) between the last byte of frame 1 and the header of frame 2.

Source files
------------

// File: rtl/byte_cmd_encoder.sv
// byte_cmd_encoder
//   Host-side transmitter for the stc0 byte command link. Write commands
//   (24-bit address, 32-bit data) are buffered in a small FIFO and each one
//   is serialized into an 8-byte frame, MSB first:
//     CMD_WRITE, addr[23:16], addr[15:8], addr[7:0],
//     data[31:24], data[23:16], data[15:8], data[7:0]
//   Frames go out on Data/DataValid, and Rdyn back-pressure is honoured.
//
// Ports
//   Clk            single clock
//   ARst           synchronous active-high reset
//   WriteAddr      command address
//   WriteData      command write data
//   WriteDataValid push request, accepted only while Ready=1
//   Ready          FIFO not full (combinational from occupancy)
//   Rdyn           receiver not ready, stalls the byte stream while high
//   Data           serialized byte (registered)
//   DataValid      Data qualifier (registered)
//   Busy           FIFO non-empty or frame in progress
//   Overflow       sticky flag, push attempted while Ready=0
//
// FSM states
//   state   | meaning
//   IDLE    | waiting for a queued command; pops it into the shift register
//   SEND    | issuing the 8 frame bytes, stalling while Rdyn=1
//   GAP     | forced idle time between frames (GAP_CYCLES cycles)

module byte_cmd_encoder #(
    parameter int         FIFO_DEPTH      = 4,
    parameter int         FIFO_DEPTH_LOG2 = 2,
    parameter int         GAP_CYCLES      = 0,
    parameter logic [7:0] CMD_WRITE       = 8'h01
) (
    input  logic        Clk,
    input  logic        ARst,
    input  logic [23:0] WriteAddr,
    input  logic [31:0] WriteData,
    input  logic        WriteDataValid,
    output logic        Ready,
    input  logic        Rdyn,
    output logic [7:0]  Data,
    output logic        DataValid,
    output logic        Busy,
    output logic        Overflow
);

    localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0]           FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]           CNT_ONE  = CNT_W'(1);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = FIFO_DEPTH_LOG2'(1);
    localparam logic [3:0]                 GAP_LOAD = 4'(GAP_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [FIFO_DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [63:0]                 shreg_q, shreg_d;
    logic [2:0]                  byte_cnt_q, byte_cnt_d;
    logic [3:0]                  gap_cnt_q, gap_cnt_d;
    logic [7:0]                  data_q, data_d;
    logic                        data_valid_q, data_valid_d;
    logic                        overflow_q, overflow_d;
    logic                        push;
    logic                        pop;

    logic [55:0] fifo_mem_q [FIFO_DEPTH];

    assign Ready     = (count_q != FULL_CNT);
    assign Data      = data_q;
    assign DataValid = data_valid_q;
    assign Busy      = (count_q != '0) | (state_q != ST_IDLE);
    assign Overflow  = overflow_q;

    // FIFO bookkeeping; a push while full is dropped and flagged.
    always_comb begin
        push       = WriteDataValid & Ready;
        overflow_d = overflow_q | (WriteDataValid & ~Ready);
        wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d   = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d    = count_q;
        if (push & ~pop) begin
            count_d = count_q + CNT_ONE;
        end else if (~push & pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Frame sequencer
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        byte_cnt_d   = byte_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        pop          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop        = 1'b1;
                    shreg_d    = {CMD_WRITE, fifo_mem_q[rd_ptr_q]};
                    byte_cnt_d = 3'd0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                // While stalled, shift register, counter and Data all hold.
                if (!Rdyn) begin
                    data_d       = shreg_q[63:56];
                    data_valid_d = 1'b1;
                    shreg_d      = {shreg_q[55:0], 8'h00};
                    byte_cnt_d   = byte_cnt_q + 3'd1;
                    if (byte_cnt_q == 3'd7) begin
                        if (GAP_CYCLES > 0) begin
                            gap_cnt_d = GAP_LOAD;
                            state_d   = ST_GAP;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q <= 4'd1) begin
                    gap_cnt_d = 4'd0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Storage array carries no reset; occupancy decides what is valid.
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {WriteAddr, WriteData};
        end
    end

    always_ff @(posedge Clk) begin
        if (ARst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            shreg_q      <= '0;
            byte_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            data_q       <= 8'h00;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            shreg_q      <= shreg_d;
            byte_cnt_q   <= byte_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            overflow_q   <= overflow_d;
        end
    end

endmodule

// File: tb/tb_byte_cmd_encoder.sv
// Bench for byte_cmd_encoder: instance A (GAP_CYCLES=0) and instance B
// (GAP_CYCLES=3). Expected frame bytes are queued on every accepted push;
// a monitor per instance pops and compares each valid byte and records
// the cycle it appeared in for the timing checks.

module tb_byte_cmd_encoder;

    localparam logic [7:0] CMD = 8'h01;

    logic        Clk = 1'b0;
    logic        ARst;
    logic        Rdyn;
    logic [23:0] WriteAddr;
    logic [31:0] WriteData;
    logic        wdv_a, wdv_b;
    logic        ready_a, dv_a, busy_a, ovf_a;
    logic        ready_b, dv_b, busy_b, ovf_b;
    logic [7:0]  data_a, data_b;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] sb_a[$];
    logic [7:0] sb_b[$];
    int         vcyc_a[$];
    int         vcyc_b[$];

    byte_cmd_encoder #(.FIFO_DEPTH(4), .FIFO_DEPTH_LOG2(2), .GAP_CYCLES(0), .CMD_WRITE(CMD)) dut_a (
        .Clk(Clk), .ARst(ARst), .WriteAddr(WriteAddr), .WriteData(WriteData),
        .WriteDataValid(wdv_a), .Ready(ready_a), .Rdyn(Rdyn), .Data(data_a),
        .DataValid(dv_a), .Busy(busy_a), .Overflow(ovf_a)
    );

    byte_cmd_encoder #(.FIFO_DEPTH(4), .FIFO_DEPTH_LOG2(2), .GAP_CYCLES(3), .CMD_WRITE(CMD)) dut_b (
        .Clk(Clk), .ARst(ARst), .WriteAddr(WriteAddr), .WriteData(WriteData),
        .WriteDataValid(wdv_b), .Ready(ready_b), .Rdyn(Rdyn), .Data(data_b),
        .DataValid(dv_b), .Busy(busy_b), .Overflow(ovf_b)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Reference frame: header then address and data bytes, MSB first.
    task automatic add_frame(input int which, input logic [23:0] a, input logic [31:0] d);
        logic [7:0] f [8];
        f[0] = CMD;
        for (int i = 0; i < 3; i++) f[1 + i] = 8'((a >> (8 * (2 - i))) & 24'hFF);
        for (int i = 0; i < 4; i++) f[4 + i] = 8'((d >> (8 * (3 - i))) & 32'hFF);
        for (int i = 0; i < 8; i++) begin
            if (which == 0) sb_a.push_back(f[i]);
            else            sb_b.push_back(f[i]);
        end
    endtask

    function automatic int qsize(input int which);
        return (which == 0) ? sb_a.size() : sb_b.size();
    endfunction

    function automatic int vget(input int which, input int idx);
        if (which == 0) return (idx < vcyc_a.size()) ? vcyc_a[idx] : -1;
        return (idx < vcyc_b.size()) ? vcyc_b[idx] : -1;
    endfunction

    // Drives one push; pe returns the clock edge number that samples it.
    task automatic push(input int which, input logic [23:0] a, input logic [31:0] d,
                        input logic exp_acc, output int pe);
        WriteAddr = a;
        WriteData = d;
        if (which == 0) begin
            check("ready_a_at_push", ready_a, exp_acc);
            wdv_a = 1'b1;
        end else begin
            check("ready_b_at_push", ready_b, exp_acc);
            wdv_b = 1'b1;
        end
        if (exp_acc) add_frame(which, a, d);
        pe = cyc + 1;
        step();
        wdv_a = 1'b0;
        wdv_b = 1'b0;
    endtask

    task automatic drain(input int which, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            if (qsize(which) == 0) done = 1'b1;
        end
        check("drain_within_budget", done, 1'b1);
    endtask

    always @(negedge Clk) begin
        if (dv_a === 1'b1) begin
            vcyc_a.push_back(cyc);
            if (sb_a.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL byte_a_unexpected: got %0h expected no byte (cycle %0d)", data_a, cyc);
            end else begin
                check("byte_a", data_a, sb_a.pop_front());
            end
        end
    end

    always @(negedge Clk) begin
        if (dv_b === 1'b1) begin
            vcyc_b.push_back(cyc);
            if (sb_b.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL byte_b_unexpected: got %0h expected no byte (cycle %0d)", data_b, cyc);
            end else begin
                check("byte_b", data_b, sb_b.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pe, pe2, pushes;

        ARst = 1'b1; Rdyn = 1'b0; wdv_a = 1'b0; wdv_b = 1'b0;
        WriteAddr = '0; WriteData = '0;
        repeat (3) step();
        check("rst_data", data_a, 8'h00);
        check("rst_valid", dv_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_overflow", ovf_a, 1'b0);
        check("rst_ready", ready_a, 1'b1);
        check("rst_ready_b", ready_b, 1'b1);
        check("rst_valid_b", dv_b, 1'b0);
        ARst = 1'b0;
        step();

        // Single command, latency and byte order
        vcyc_a.delete();
        push(0, 24'h000104, 32'hDEADBEEF, 1'b1, pe);
        check("busy_after_push", busy_a, 1'b1);
        drain(0, 40);
        check("busy_after_frame", busy_a, 1'b0);
        check("single_nbytes", vcyc_a.size(), 8);
        check("single_first_cycle", vget(0, 0), pe + 2);
        check("single_last_cycle", vget(0, 7), pe + 9);
        repeat (3) step();

        // Three back-to-back commands
        vcyc_a.delete();
        push(0, 24'h000001, 32'h11111111, 1'b1, pe);
        push(0, 24'h000002, 32'h22222222, 1'b1, pe2);
        push(0, 24'h000003, 32'h33333333, 1'b1, pe2);
        drain(0, 100);
        check("b2b_nbytes", vcyc_a.size(), 24);
        check("b2b_first_cycle", vget(0, 0), pe + 2);
        check("b2b_gap1", vget(0, 8) - vget(0, 7), 2);
        check("b2b_gap2", vget(0, 16) - vget(0, 15), 2);
        check("b2b_last_cycle", vget(0, 23), pe + 27);
        check("b2b_ready", ready_a, 1'b1);
        repeat (3) step();

        // Three-cycle stall after byte 2
        vcyc_a.delete();
        push(0, 24'h5A1234, 32'hCAFEF00D, 1'b1, pe);
        repeat (4) step();
        Rdyn = 1'b1;
        step();
        check("stall_valid_low", dv_a, 1'b0);
        check("stall_data_hold", data_a, 8'h12);
        repeat (2) step();
        Rdyn = 1'b0;
        drain(0, 40);
        check("stall_nbytes", vcyc_a.size(), 8);
        check("stall_resume_gap", vget(0, 3) - vget(0, 2), 4);
        check("stall_last_cycle", vget(0, 7), pe + 12);
        repeat (3) step();

        // Fill to overflow with the receiver stalled
        vcyc_a.delete();
        Rdyn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(0, 24'h100000 + 24'(i), $urandom, 1'b1, pe);
        end
        check("ovf_before", ovf_a, 1'b0);
        push(0, 24'h1FFFFF, 32'hBAD0BAD0, 1'b0, pe);
        check("ovf_after", ovf_a, 1'b1);
        check("ovf_ready_low", ready_a, 1'b0);
        check("ovf_no_bytes_while_stalled", vcyc_a.size(), 0);
        Rdyn = 1'b0;
        drain(0, 200);
        check("ovf_nbytes", vcyc_a.size(), 40);
        check("ovf_sticky", ovf_a, 1'b1);
        check("ovf_ready_back", ready_a, 1'b1);

        // Reset mid-frame with two commands queued
        ARst = 1'b1;
        step();
        ARst = 1'b0;
        check("ovf_cleared", ovf_a, 1'b0);
        vcyc_a.delete();
        push(0, 24'hA00001, 32'h0A0A0A0A, 1'b1, pe);
        push(0, 24'hA00002, 32'h0B0B0B0B, 1'b1, pe2);
        push(0, 24'hA00003, 32'h0C0C0C0C, 1'b1, pe2);
        repeat (4) step();
        ARst = 1'b1;
        step();
        sb_a.delete();
        check("rstmid_valid", dv_a, 1'b0);
        check("rstmid_busy", busy_a, 1'b0);
        check("rstmid_ready", ready_a, 1'b1);
        ARst = 1'b0;
        repeat (15) step();
        check("rstmid_nbytes", vcyc_a.size(), 5);
        check("rstmid_busy_later", busy_a, 1'b0);

        // Forced inter-frame gap on instance B
        vcyc_b.delete();
        push(1, 24'hABCDEF, 32'h01234567, 1'b1, pe);
        push(1, 24'h123456, 32'h89ABCDEF, 1'b1, pe2);
        drain(1, 100);
        check("gap_nbytes", vcyc_b.size(), 16);
        check("gap_first_cycle", vget(1, 0), pe + 2);
        check("gap_between_frames", vget(1, 8) - vget(1, 7), 5);
        repeat (3) step();

        // Random commands with random receiver stalls
        pushes = 0;
        for (int i = 0; i < 600 && pushes < 20; i++) begin
            Rdyn = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) != 0 && sb_a.size() <= 24) begin
                push(0, 24'($urandom), $urandom, 1'b1, pe);
                pushes++;
            end else begin
                step();
            end
        end
        Rdyn = 1'b0;
        check("rand_all_pushed", pushes, 20);
        drain(0, 400);
        check("rand_busy_end", busy_a, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
